// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator.
// Command field positions, FSM states and the voice record.
package synth_pkg;

   localparam logic [6:0] NOTE_OFF = 7'd0;
   localparam logic [6:0] STOP_ALL = 7'h7F;

   localparam int CMD_ON_BIT  = 15;
   localparam int CMD_NOTE_HI = 14;
   localparam int CMD_NOTE_LO = 8;
   localparam int CMD_RSVD    = 7;
   localparam int CMD_VEL_HI  = 6;
   localparam int CMD_VEL_LO  = 0;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } alloc_state_t;

   typedef struct packed {
      logic [6:0] note;
      logic [6:0] vel;
      logic [7:0] age;
   } voice_t;

endpackage

// File: rtl/voice_allocator_p_voice_slot.sv
// One voice slot: note, velocity and a saturating age.
// Clear beats load; age only advances while occupied.
module voice_slot #(
   parameter int NOTE_W = 7,
   parameter int VEL_W  = 7,
   parameter int AGE_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic              age_inc,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [VEL_W-1:0]  vel_in,
   output logic [NOTE_W-1:0] note,
   output logic [VEL_W-1:0]  vel,
   output logic [AGE_W-1:0]  age
);

   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   // slot state: clear, load (fresh age) or age step
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         note <= '0;
         vel  <= '0;
         age  <= '0;
      end else if (load) begin
         note <= note_in;
         vel  <= vel_in;
         age  <= '0;
      end else if (age_inc && note != '0 && age != AGE_MAX) begin
         age <= age + 1'b1;
      end
   end

endmodule

// File: rtl/voice_allocator_p.sv
// Voice allocator: sequential slot scan, commit, round-robin dispatch.
// Macro VOICE_STEAL_EN: a full note-on steals the oldest slot.
module voice_allocator_p
   import synth_pkg::*;
#(
   parameter int NVOICES = 10,
   parameter int NOTE_W  = 7,
   parameter int VEL_W   = 7,
   parameter int AGE_W   = 8,
   parameter int IDX_W   = $clog2(NVOICES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              i_cmd_valid,
   input  logic [15:0]       i_cmd,
   output logic              o_cmd_ready,
   output logic [NOTE_W-1:0] o_midi,
   output logic [VEL_W-1:0]  o_vel,
   output logic [IDX_W-1:0]  o_voice_idx,
   output logic              o_valid,
   output logic [IDX_W:0]    o_active_cnt,
   output logic              o_event
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NVOICES - 1);

   alloc_state_t state, state_nxt;

   logic [NOTE_W-1:0] s_note [NVOICES];
   logic [VEL_W-1:0]  s_vel  [NVOICES];
   logic [AGE_W-1:0]  s_age  [NVOICES];

   logic [NVOICES-1:0] load, clear, inc;
   logic [IDX_W-1:0]   scan_idx, ptr, tgt;
   logic [IDX_W-1:0]   m_idx, f_idx, o_idx;
   logic [AGE_W-1:0]   o_age;
   logic               hit_m, hit_f, hit_o;
   logic               cmd_on, do_load, event_nxt;
   logic [NOTE_W-1:0]  cmd_note, in_note;
   logic [VEL_W-1:0]   cmd_vel, in_vel;
   logic               in_on, accept, stop_go, start_go;
   logic [IDX_W:0]     cnt_nxt;
   logic               unused_rsvd;

   assign unused_rsvd = i_cmd[CMD_RSVD];

   assign in_note  = NOTE_W'(i_cmd[CMD_NOTE_HI:CMD_NOTE_LO]);
   assign in_vel   = VEL_W'(i_cmd[CMD_VEL_HI:CMD_VEL_LO]);
   assign in_on    = i_cmd[CMD_ON_BIT] &&
                     (i_cmd[CMD_VEL_HI:CMD_VEL_LO] != '0);

   assign o_cmd_ready = (state == IDLE);
   assign accept   = i_cmd_valid && o_cmd_ready;
   assign stop_go  = accept && !in_on &&
                     (in_note == NOTE_W'(STOP_ALL));
   assign start_go = accept && !stop_go &&
                     (in_note != NOTE_W'(NOTE_OFF));

   for (genvar g = 0; g < NVOICES; g++) begin : g_slot
      voice_slot #(
         .NOTE_W (NOTE_W),
         .VEL_W  (VEL_W),
         .AGE_W  (AGE_W)
      ) u_slot (
         .clk     (clk),
         .reset   (reset),
         .load    (load[g]),
         .clear   (clear[g]),
         .age_inc (inc[g]),
         .note_in (cmd_note),
         .vel_in  (cmd_vel),
         .note    (s_note[g]),
         .vel     (s_vel[g]),
         .age     (s_age[g])
      );
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_go) state_nxt = SCAN;
         SCAN:    if (scan_idx == LAST) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // command latch and one-slot-per-cycle scan bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_on   <= 1'b0;
         cmd_note <= '0;
         cmd_vel  <= '0;
         scan_idx <= '0;
         hit_m    <= 1'b0;
         hit_f    <= 1'b0;
         hit_o    <= 1'b0;
         m_idx    <= '0;
         f_idx    <= '0;
         o_idx    <= '0;
         o_age    <= '0;
      end else if (start_go) begin
         cmd_on   <= in_on;
         cmd_note <= in_note;
         cmd_vel  <= in_vel;
         scan_idx <= '0;
         hit_m    <= 1'b0;
         hit_f    <= 1'b0;
         hit_o    <= 1'b0;
      end else if (state == SCAN) begin
         scan_idx <= scan_idx + 1'b1;
         if (!hit_m && s_note[scan_idx] == cmd_note) begin
            hit_m <= 1'b1;
            m_idx <= scan_idx;
         end
         if (!hit_f && s_note[scan_idx] == '0) begin
            hit_f <= 1'b1;
            f_idx <= scan_idx;
         end
         if (s_note[scan_idx] != '0 &&
             (!hit_o || s_age[scan_idx] > o_age)) begin
            hit_o <= 1'b1;
            o_idx <= scan_idx;
            o_age <= s_age[scan_idx];
         end
      end
   end

`ifndef VOICE_STEAL_EN
   logic unused_oldest;
   assign unused_oldest = ^o_idx;
`endif

   // commit decision: slot strobes and event
   always_comb begin
      load      = '0;
      clear     = '0;
      inc       = '0;
      tgt       = '0;
      do_load   = 1'b0;
      event_nxt = 1'b0;
      if (stop_go) clear = '1;
      if (state == COMMIT) begin
         if (cmd_on) begin
            unique case (1'b1)
               hit_m: begin
                  do_load = 1'b1;
                  tgt     = m_idx;
               end
               (hit_f && !hit_m): begin
                  do_load = 1'b1;
                  tgt     = f_idx;
               end
               default: begin
                  event_nxt = 1'b1;
`ifdef VOICE_STEAL_EN
                  do_load   = 1'b1;
                  tgt       = o_idx;
`endif
               end
            endcase
            if (do_load) begin
               load[tgt] = 1'b1;
               inc       = ~load;
            end
         end else if (hit_m) begin
            clear[m_idx] = 1'b1;
         end
      end
   end

   // event pulse
   always_ff @(posedge clk) begin
      if (reset) o_event <= 1'b0;
      else       o_event <= event_nxt;
   end

   // round-robin dispatch, reads pre-write slot values
   always_ff @(posedge clk) begin
      if (reset) begin
         o_midi      <= '0;
         o_vel       <= '0;
         o_voice_idx <= '0;
         o_valid     <= 1'b0;
         ptr         <= '0;
      end else if (clk_en) begin
         o_midi      <= s_note[ptr];
         o_vel       <= s_vel[ptr];
         o_voice_idx <= ptr;
         o_valid     <= (s_note[ptr] != '0);
         ptr         <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

   // occupied-slot population count
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NVOICES; i++)
         cnt_nxt = cnt_nxt + (IDX_W+1)'(s_note[i] != '0);
   end

   // registered count, one cycle behind the slots
   always_ff @(posedge clk) begin
      if (reset) o_active_cnt <= '0;
      else       o_active_cnt <= cnt_nxt;
   end

endmodule

// File: tb/tb_voice_allocator_p.sv
// Directed bench for voice_allocator_p with NVOICES=4.
// Slot model plus dispatch scoreboard queue.
module tb_voice_allocator_p;
   import synth_pkg::*;

   localparam int NV = 4;

   logic        clk = 1'b0;
   logic        reset, clk_en, i_cmd_valid;
   logic [15:0] i_cmd;
   logic        o_cmd_ready, o_valid, o_event;
   logic [6:0]  o_midi, o_vel;
   logic [1:0]  o_voice_idx;
   logic [2:0]  o_active_cnt;

   always #5 clk = ~clk;

   voice_allocator_p #(.NVOICES(NV)) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .i_cmd_valid  (i_cmd_valid),
      .i_cmd        (i_cmd),
      .o_cmd_ready  (o_cmd_ready),
      .o_midi       (o_midi),
      .o_vel        (o_vel),
      .o_voice_idx  (o_voice_idx),
      .o_valid      (o_valid),
      .o_active_cnt (o_active_cnt),
      .o_event      (o_event)
   );

   logic [7:0] age_mon [NV];
   assign age_mon[0] = dut.g_slot[0].u_slot.age;
   assign age_mon[1] = dut.g_slot[1].u_slot.age;
   assign age_mon[2] = dut.g_slot[2].u_slot.age;
   assign age_mon[3] = dut.g_slot[3].u_slot.age;

   typedef struct {
      int     idx;
      voice_t v;
   } exp_t;

   voice_t m [NV];
   exp_t   q [$];
   exp_t   last_e;
   int     m_ptr;
   int     n_cmp = 0;
   int     n_err = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < NV; i++) if (m[i].note != 0) c++;
      return c;
   endfunction

   function automatic logic [15:0] mk(input bit on, input int nt,
                                      input int vl);
      return {on, 7'(nt), 1'b0, 7'(vl)};
   endfunction

   task automatic chk_ages(input string tag);
      for (int i = 0; i < NV; i++)
         chk($sformatf("%s age%0d", tag, i), age_mon[i], m[i].age);
   endtask

   task automatic model_apply(input logic [15:0] cmd, output bit ev,
                              output int kind);
      logic [6:0] nt, vl;
      bit on;
      int t, mi, fi, oi;
      nt = cmd[14:8];
      vl = cmd[6:0];
      on = cmd[15] && (vl != 0);
      ev = 0;
      kind = 2;
      if (nt == 0) kind = 0;
      else if (!on && nt == 7'h7F) begin
         kind = 1;
         for (int i = 0; i < NV; i++) m[i] = '0;
      end else begin
         mi = -1; fi = -1; oi = -1;
         for (int i = 0; i < NV; i++) begin
            if (mi < 0 && m[i].note == nt) mi = i;
            if (fi < 0 && m[i].note == 0) fi = i;
            if (m[i].note != 0 && (oi < 0 || m[i].age > m[oi].age)) oi = i;
         end
         if (!on) begin
            if (mi >= 0) m[mi] = '0;
         end else begin
            t = (mi >= 0) ? mi : fi;
            if (t < 0) begin
               ev = 1;
`ifdef VOICE_STEAL_EN
               t = oi;
`endif
            end
            if (t >= 0) begin
               for (int j = 0; j < NV; j++)
                  if (j != t && m[j].note != 0 && m[j].age != 8'hFF)
                     m[j].age = m[j].age + 8'd1;
               m[t].note = nt;
               m[t].vel  = vl;
               m[t].age  = 8'd0;
            end
         end
      end
   endtask

   task automatic send_cmd(input string tag, input logic [15:0] cmd);
      bit ev;
      int kind, n;
      n = 0;
      while (!o_cmd_ready && n < 50) begin
         tick();
         n++;
      end
      chk({tag, " rdy_wait"}, o_cmd_ready, 1);
      model_apply(cmd, ev, kind);
      i_cmd = cmd;
      i_cmd_valid = 1'b1;
      tick();
      i_cmd_valid = 1'b0;
      if (kind == 2) begin
         chk({tag, " busy"}, o_cmd_ready, 0);
         repeat (4) tick();
         chk({tag, " busy_commit"}, o_cmd_ready, 0);
         tick();
         chk({tag, " ready"}, o_cmd_ready, 1);
         chk({tag, " event"}, o_event, ev);
         chk_ages(tag);
         tick();
         chk({tag, " event_end"}, o_event, 0);
         chk({tag, " cnt"}, o_active_cnt, m_cnt());
      end else begin
         chk({tag, " ready_stay"}, o_cmd_ready, 1);
         chk_ages(tag);
         tick();
         chk({tag, " cnt"}, o_active_cnt, m_cnt());
         chk({tag, " event"}, o_event, 0);
      end
   endtask

   task automatic dispatch(input int n);
      exp_t e;
      clk_en = 1'b1;
      repeat (n) begin
         e.idx = m_ptr;
         e.v   = m[m_ptr];
         q.push_back(e);
         m_ptr = (m_ptr + 1) % NV;
         tick();
         e = q.pop_front();
         chk("disp idx", o_voice_idx, e.idx);
         chk("disp midi", o_midi, e.v.note);
         chk("disp vel", o_vel, e.v.vel);
         chk("disp valid", o_valid, e.v.note != 0);
         last_e = e;
      end
      clk_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clk_en = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd = '0;
      for (int i = 0; i < NV; i++) m[i] = '0;
      m_ptr = 0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst ready", o_cmd_ready, 1);
      chk("rst midi", o_midi, 0);
      chk("rst vel", o_vel, 0);
      chk("rst idx", o_voice_idx, 0);
      chk("rst valid", o_valid, 0);
      chk("rst cnt", o_active_cnt, 0);
      chk("rst event", o_event, 0);

      send_cmd("on60", mk(1, 60, 100));
      dispatch(8);

      send_cmd("on62", mk(1, 62, 80));
      send_cmd("on64", mk(1, 64, 70));
      send_cmd("on65", mk(1, 65, 60));
      send_cmd("on67_full", mk(1, 67, 50));
      dispatch(4);

      send_cmd("retrig62", mk(1, 62, 90));
      dispatch(4);
      send_cmd("off62", mk(0, 62, 0));

      send_cmd("stop_all", 16'h7F00);

      send_cmd("on70", mk(1, 70, 30));
      send_cmd("on70_v0", mk(1, 70, 0));
      send_cmd("off71", mk(0, 71, 0));
      send_cmd("note0", mk(1, 0, 5));

      send_cmd("on50", mk(1, 50, 40));
      dispatch(5);
      repeat (10) tick();
      chk("frozen idx", o_voice_idx, last_e.idx);
      chk("frozen midi", o_midi, last_e.v.note);
      chk("frozen vel", o_vel, last_e.v.vel);
      chk("frozen valid", o_valid, last_e.v.note != 0);

      i_cmd = mk(1, 72, 10);
      i_cmd_valid = 1'b1;
      tick();
      i_cmd_valid = 1'b0;
      repeat (2) tick();
      chk("scan busy", o_cmd_ready, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < NV; i++) m[i] = '0;
      m_ptr = 0;
      chk("midrst ready", o_cmd_ready, 1);
      chk("midrst midi", o_midi, 0);
      chk("midrst cnt", o_active_cnt, 0);
      chk_ages("midrst");
      repeat (6) tick();
      chk("midrst idle", o_cmd_ready, 1);
      chk("midrst cnt2", o_active_cnt, 0);
      dispatch(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
